// File: rtl/pkt_dequeue_pkg.sv
// Shared widths, word flags, FSM encoding and helpers for the packet dequeue engine.
package pkt_dequeue_pkg;

  localparam int unsigned DATA_W    = 134;
  localparam int unsigned NUM_Q     = 8;
  localparam int unsigned QIDX_W    = $clog2(NUM_Q);
  localparam int unsigned FLAG_W    = 2;
  localparam int unsigned WCNT_W    = 10;
  localparam int unsigned PKT_CNT_W = 32;
  localparam int unsigned ERR_CNT_W = 16;

  localparam logic [FLAG_W-1:0] FLAG_HEAD = 2'b01;
  localparam logic [FLAG_W-1:0] FLAG_MID  = 2'b11;
  localparam logic [FLAG_W-1:0] FLAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [FLAG_W-1:0]        flags;
    logic [DATA_W-FLAG_W-1:0] payload;
  } pkt_word_t;

  function automatic logic is_onehot(input logic [NUM_Q-1:0] v);
    return (v != '0) && ((v & (v - NUM_Q'(1))) == '0);
  endfunction

  function automatic logic [QIDX_W-1:0] onehot_idx(input logic [NUM_Q-1:0] v);
    logic [QIDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      if (v[i]) idx = QIDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pkt_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module pkt_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pkt_dequeue.sv
// Drains one granted show-ahead queue packet-by-packet into the output FIFO,
// dropping malformed packets and truncating oversize ones.
module pkt_dequeue
  import pkt_dequeue_pkg::*;
#(
  parameter string       PLATFORM  = "xilinx",
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_Q-1:0]        in_sel,
  input  logic [NUM_Q*DATA_W-1:0] in_q_data,
  input  logic [NUM_Q-1:0]        in_q_empty,
  output logic [NUM_Q-1:0]        out_q_rden,
  output logic [DATA_W-1:0]       out_pkt_data,
  output logic                    out_pkt_valid,
  output logic                    out_outport_free,
  output logic [PKT_CNT_W-1:0]    out_pkt_cnt,
  output logic [ERR_CNT_W-1:0]    out_err_cnt
);

  state_t            state;
  logic [QIDX_W-1:0] q_idx;
  logic              first_word;
  logic [WCNT_W-1:0] word_cnt;
  pkt_word_t         out_word;

  pkt_word_t         heads_c [NUM_Q];
  pkt_word_t         head_c;
  logic              q_empty_c;
  logic              pop_c;
  logic              tail_c;
  logic              last_slot_c;
  logic              sel_err_c;
  logic              first_empty_c;
  logic              bad_head_c;
  logic              overflow_c;
  logic              err_inc_c;
  logic              pkt_inc_c;
  logic [NUM_Q-1:0]  rden_c;

  // Head-word decode of the granted queue and per-cycle event detection.
  always_comb begin
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      heads_c[i] = pkt_word_t'(in_q_data[i*DATA_W +: DATA_W]);
    end
    head_c      = heads_c[q_idx];
    q_empty_c   = in_q_empty[q_idx];
    pop_c       = ((state == ST_READ) || (state == ST_DISCARD)) && !q_empty_c;
    tail_c      = (head_c.flags == FLAG_TAIL);
    last_slot_c = (word_cnt == WCNT_W'(MAX_WORDS - 1));

    sel_err_c     = (state == ST_IDLE) ? ((in_sel != '0) && !is_onehot(in_sel))
                                       : (in_sel != '0);
    first_empty_c = (state == ST_READ) && first_word && q_empty_c;
    bad_head_c    = (state == ST_READ) && first_word && pop_c && (head_c.flags != FLAG_HEAD);
    overflow_c    = (state == ST_READ) && pop_c && !bad_head_c && !tail_c && last_slot_c;

    // Coincident error sources collapse into a single increment.
    err_inc_c = sel_err_c | first_empty_c | bad_head_c | overflow_c;
    pkt_inc_c = (state == ST_READ) && pop_c && !bad_head_c && (tail_c || last_slot_c);

    rden_c = '0;
    if (pop_c) rden_c[q_idx] = 1'b1;
  end

  // Vendor hook: both targets currently drive the pop strobes straight from the decode.
  if (PLATFORM == "xilinx") begin : g_rden_xilinx
    assign out_q_rden = rden_c;
  end else begin : g_rden_generic
    assign out_q_rden = rden_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      q_idx            <= '0;
      first_word       <= 1'b0;
      word_cnt         <= '0;
      out_word         <= '0;
      out_pkt_valid    <= 1'b0;
      out_outport_free <= 1'b0;
    end else begin
      out_pkt_valid    <= 1'b0;
      out_outport_free <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (is_onehot(in_sel)) begin
            q_idx      <= onehot_idx(in_sel);
            first_word <= 1'b1;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (q_empty_c) begin
            if (first_word) begin
              state            <= ST_DONE;
              out_outport_free <= 1'b1;
            end
          end else begin
            word_cnt   <= word_cnt + WCNT_W'(1);
            first_word <= 1'b0;
            if (bad_head_c) begin
              state <= ST_DISCARD;
            end else begin
              out_word      <= head_c;
              out_pkt_valid <= 1'b1;
              if (tail_c) begin
                state            <= ST_DONE;
                out_outport_free <= 1'b1;
              end else if (last_slot_c) begin
                // Truncated packet: close it downstream, then drop the remainder.
                out_word.flags <= FLAG_TAIL;
                state          <= ST_DISCARD;
              end
            end
          end
        end
        ST_DISCARD: begin
          if (pop_c && tail_c) begin
            state            <= ST_DONE;
            out_outport_free <= 1'b1;
          end
        end
        ST_DONE: begin
          word_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_pkt_data = out_word;

  pkt_sat_cnt #(.WIDTH(PKT_CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pkt_inc_c),
    .cnt   (out_pkt_cnt)
  );

  pkt_sat_cnt #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc_c),
    .cnt   (out_err_cnt)
  );

endmodule

// File: tb/tb_pkt_dequeue.sv
// Bench for pkt_dequeue: software queues feed the DUT, a packet-level model predicts each grant.
module tb_pkt_dequeue;
  import pkt_dequeue_pkg::*;

  localparam int MAXW   = 128;
  localparam int REFILL = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_Q-1:0]        in_sel;
  logic [NUM_Q*DATA_W-1:0] in_q_data;
  logic [NUM_Q-1:0]        in_q_empty;
  logic [NUM_Q-1:0]        out_q_rden;
  logic [DATA_W-1:0]       out_pkt_data;
  logic                    out_pkt_valid;
  logic                    out_outport_free;
  logic [PKT_CNT_W-1:0]    out_pkt_cnt;
  logic [ERR_CNT_W-1:0]    out_err_cnt;

  pkt_dequeue #(.PLATFORM("xilinx"), .MAX_WORDS(MAXW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_sel           (in_sel),
    .in_q_data        (in_q_data),
    .in_q_empty       (in_q_empty),
    .out_q_rden       (out_q_rden),
    .out_pkt_data     (out_pkt_data),
    .out_pkt_valid    (out_pkt_valid),
    .out_outport_free (out_outport_free),
    .out_pkt_cnt      (out_pkt_cnt),
    .out_err_cnt      (out_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] tbq [NUM_Q][$];
  logic [DATA_W-1:0] got_words[$];
  logic [DATA_W-1:0] exp_words[$];
  int got_cyc[$];
  int free_cyc[$];
  int rden_hits [NUM_Q];
  int cyc;
  int n_tests;
  int n_fail;
  int exp_pkt;
  int exp_err;
  int exp_pops;
  int exp_dpkt;
  int exp_derr;

  function automatic logic [DATA_W-1:0] mkw(input logic [1:0] f);
    logic [DATA_W-1:0] w;
    for (int b = 0; b < DATA_W - 2; b++) w[b] = 1'($urandom);
    w[DATA_W-1 -: 2] = f;
    return w;
  endfunction

  task automatic push_pkt(input int q, input int len, input logic [1:0] head_flag);
    for (int i = 0; i < len; i++) begin
      if (i == 0)            tbq[q].push_back(mkw(head_flag));
      else if (i == len - 1) tbq[q].push_back(mkw(FLAG_TAIL));
      else                   tbq[q].push_back(mkw(FLAG_MID));
    end
  endtask

  task automatic drive_q();
    for (int i = 0; i < NUM_Q; i++) begin
      in_q_empty[i] = (tbq[i].size() == 0);
      in_q_data[i*DATA_W +: DATA_W] = (tbq[i].size() != 0) ? tbq[i][0] : '0;
    end
  endtask

  task automatic clear_capture();
    got_words.delete();
    got_cyc.delete();
    free_cyc.delete();
    for (int i = 0; i < NUM_Q; i++) rden_hits[i] = 0;
  endtask

  // One clock: observe mid-cycle, then apply the pops the DUT performed at the edge.
  task automatic step();
    logic [NUM_Q-1:0] pop;
    @(negedge clk);
    pop = out_q_rden;
    for (int i = 0; i < NUM_Q; i++) if (pop[i]) rden_hits[i]++;
    if (out_pkt_valid) begin
      got_words.push_back(out_pkt_data);
      got_cyc.push_back(cyc);
    end
    if (out_outport_free) free_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_Q; i++) begin
      if (pop[i] && tbq[i].size() != 0) void'(tbq[i].pop_front());
    end
    drive_q();
  endtask

  task automatic grant(input int q);
    in_sel = NUM_Q'(1) << q;
    step();
    in_sel = '0;
  endtask

  task automatic wait_free(input int budget, output bit ok);
    int n0;
    n0 = free_cyc.size();
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      ok = (free_cyc.size() > n0);
    end
    step();
    step();
  endtask

  // Packet-level prediction of one grant from the queue contents.
  task automatic model(input logic [DATA_W-1:0] pkt[$]);
    logic [DATA_W-1:0] w;
    int j;
    exp_words.delete();
    exp_pops = 0;
    exp_dpkt = 0;
    exp_derr = 0;
    if (pkt.size() == 0) begin
      exp_derr = 1;
      return;
    end
    w = pkt[0];
    if (w[DATA_W-1 -: 2] != FLAG_HEAD) begin
      exp_derr = 1;
      j = 1;
      while (j < pkt.size() && pkt[j][DATA_W-1 -: 2] != FLAG_TAIL) j++;
      exp_pops = j + 1;
      return;
    end
    for (int i = 0; i < pkt.size(); i++) begin
      w = pkt[i];
      if (w[DATA_W-1 -: 2] == FLAG_TAIL) begin
        exp_words.push_back(w);
        exp_dpkt = 1;
        exp_pops = i + 1;
        return;
      end
      if (i == MAXW - 1) begin
        w[DATA_W-1 -: 2] = FLAG_TAIL;
        exp_words.push_back(w);
        exp_dpkt = 1;
        exp_derr = 1;
        j = i + 1;
        while (j < pkt.size() && pkt[j][DATA_W-1 -: 2] != FLAG_TAIL) j++;
        exp_pops = j + 1;
        return;
      end
      exp_words.push_back(w);
    end
  endtask

  function automatic int word_mismatches();
    int m;
    m = 0;
    if (got_words.size() != exp_words.size()) return -1;
    for (int i = 0; i < got_words.size(); i++) if (got_words[i] !== exp_words[i]) m++;
    return m;
  endfunction

  function automatic int other_rden(input int q);
    int s;
    s = 0;
    for (int i = 0; i < NUM_Q; i++) if (i != q) s += rden_hits[i];
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_sel = '0;
    drive_q();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_q_rden !== '0) begin n_fail++; $display("FAIL reset_rden got=%h want=0", out_q_rden); end
    n_tests++; if (out_pkt_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", out_pkt_data); end
    n_tests++; if (out_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_pkt_valid); end
    n_tests++; if (out_outport_free !== 1'b0) begin n_fail++; $display("FAIL reset_free got=%b want=0", out_outport_free); end
    n_tests++; if (out_pkt_cnt !== '0) begin n_fail++; $display("FAIL reset_pkt_cnt got=%0d want=0", out_pkt_cnt); end
    n_tests++; if (out_err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d want=0", out_err_cnt); end
    push_pkt(3, 3, FLAG_HEAD);
    drive_q();
    @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
    repeat (3) step();
    n_tests++; if (other_rden(-1) != 0 || got_words.size() != 0) begin
      n_fail++; $display("FAIL idle_no_grant rden=%0d words=%0d want 0/0", other_rden(-1), got_words.size());
    end
    tbq[3].delete();
    drive_q();
  endtask

  task automatic test_basic();
    bit ok;
    int g;
    clear_capture();
    tbq[2].push_back(mkw(FLAG_HEAD));
    tbq[2].push_back(mkw(FLAG_MID));
    tbq[2].push_back(mkw(FLAG_MID));
    tbq[2].push_back(mkw(FLAG_TAIL));
    drive_q();
    model(tbq[2]);
    g = cyc;
    grant(2);
    wait_free(40, ok);
    exp_pkt += exp_dpkt; exp_err += exp_derr;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_free_seen got=0 want=1"); end
    n_tests++; if (rden_hits[2] != 4 || other_rden(2) != 0) begin
      n_fail++; $display("FAIL basic_rden q2=%0d others=%0d want 4/0", rden_hits[2], other_rden(2));
    end
    n_tests++; if (word_mismatches() != 0) begin
      n_fail++; $display("FAIL basic_words mism=%0d got_n=%0d want_n=%0d", word_mismatches(), got_words.size(), exp_words.size());
    end
    n_tests++; if (got_cyc.size() == 0 || got_cyc[0] != g + 2) begin
      n_fail++; $display("FAIL basic_latency got=%0d want=%0d", (got_cyc.size() != 0) ? got_cyc[0] : -1, g + 2);
    end
    n_tests++; if (free_cyc.size() != 1 || got_cyc.size() == 0 || free_cyc[0] != got_cyc[got_cyc.size()-1]) begin
      n_fail++; $display("FAIL basic_free_with_tail pulses=%0d want 1 coinciding with tail", free_cyc.size());
    end
    n_tests++; if (out_pkt_cnt !== PKT_CNT_W'(exp_pkt)) begin n_fail++; $display("FAIL basic_pkt_cnt got=%0d want=%0d", out_pkt_cnt, exp_pkt); end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] pkt[$];
    bit ok;
    int n;
    clear_capture();
    pkt.push_back(mkw(FLAG_HEAD));
    pkt.push_back(mkw(FLAG_MID));
    pkt.push_back(mkw(FLAG_MID));
    pkt.push_back(mkw(FLAG_TAIL));
    model(pkt);
    tbq[5].push_back(pkt[0]);
    drive_q();
    grant(5);
    n = 0;
    while (tbq[5].size() != 0 && n < 10) begin step(); n++; end
    repeat (REFILL) step();
    for (int i = 1; i < pkt.size(); i++) tbq[5].push_back(pkt[i]);
    drive_q();
    wait_free(40, ok);
    exp_pkt += exp_dpkt; exp_err += exp_derr;
    n_tests++; if (!ok || word_mismatches() != 0) begin
      n_fail++; $display("FAIL stall_words free=%0b mism=%0d got_n=%0d want_n=%0d", ok, word_mismatches(), got_words.size(), exp_words.size());
    end
    n_tests++; if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != REFILL + 1) begin
      n_fail++; $display("FAIL stall_gap got=%0d want=%0d", (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1, REFILL + 1);
    end
    n_tests++; if (out_err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL stall_err_cnt got=%0d want=%0d", out_err_cnt, exp_err); end
  endtask

  task automatic test_sel_err();
    bit ok;
    clear_capture();
    push_pkt(0, 3, FLAG_HEAD);
    push_pkt(1, 6, FLAG_HEAD);
    push_pkt(4, 3, FLAG_HEAD);
    drive_q();
    in_sel = 8'b0000_0011;
    step();
    in_sel = '0;
    step();
    exp_err++;
    n_tests++; if (other_rden(-1) != 0) begin n_fail++; $display("FAIL multi_sel_rden got=%0d want=0", other_rden(-1)); end
    n_tests++; if (out_err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL multi_sel_err got=%0d want=%0d", out_err_cnt, exp_err); end
    clear_capture();
    model(tbq[1]);
    grant(1);
    step();
    in_sel = 8'b0001_0000;
    step();
    in_sel = '0;
    wait_free(40, ok);
    exp_pkt += exp_dpkt; exp_err += exp_derr + 1;
    n_tests++; if (!ok || rden_hits[1] != exp_pops || other_rden(1) != 0) begin
      n_fail++; $display("FAIL busy_sel_rden free=%0b q1=%0d others=%0d want %0d/0", ok, rden_hits[1], other_rden(1), exp_pops);
    end
    n_tests++; if (word_mismatches() != 0) begin n_fail++; $display("FAIL busy_sel_words mism=%0d want 0", word_mismatches()); end
    n_tests++; if (out_err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL busy_sel_err got=%0d want=%0d", out_err_cnt, exp_err); end
    tbq[0].delete();
    tbq[4].delete();
    drive_q();
  endtask

  task automatic test_overflow();
    bit ok;
    for (int len = 200; len >= 128; len -= 72) begin
      clear_capture();
      push_pkt(0, len, FLAG_HEAD);
      drive_q();
      model(tbq[0]);
      grant(0);
      wait_free(400, ok);
      exp_pkt += exp_dpkt; exp_err += exp_derr;
      n_tests++; if (!ok || free_cyc.size() != 1 || rden_hits[0] != len) begin
        n_fail++; $display("FAIL ovf%0d_pops free=%0d rden=%0d want 1/%0d", len, free_cyc.size(), rden_hits[0], len);
      end
      n_tests++; if (got_words.size() != MAXW || word_mismatches() != 0) begin
        n_fail++; $display("FAIL ovf%0d_words got_n=%0d want_n=%0d mism=%0d", len, got_words.size(), MAXW, word_mismatches());
      end
      n_tests++; if (out_pkt_cnt !== PKT_CNT_W'(exp_pkt) || out_err_cnt !== ERR_CNT_W'(exp_err)) begin
        n_fail++; $display("FAIL ovf%0d_cnts pkt=%0d err=%0d want %0d/%0d", len, out_pkt_cnt, out_err_cnt, exp_pkt, exp_err);
      end
    end
  endtask

  task automatic test_bad_head();
    bit ok;
    clear_capture();
    push_pkt(7, 4, FLAG_MID);
    push_pkt(7, 2, FLAG_HEAD);
    drive_q();
    model(tbq[7]);
    grant(7);
    wait_free(40, ok);
    exp_pkt += exp_dpkt; exp_err += exp_derr;
    n_tests++; if (!ok || got_words.size() != 0 || rden_hits[7] != exp_pops || tbq[7].size() != 2) begin
      n_fail++; $display("FAIL bad_head_drain free=%0b words=%0d pops=%0d left=%0d want 1/0/%0d/2", ok, got_words.size(), rden_hits[7], tbq[7].size(), exp_pops);
    end
    n_tests++; if (out_err_cnt !== ERR_CNT_W'(exp_err) || out_pkt_cnt !== PKT_CNT_W'(exp_pkt)) begin
      n_fail++; $display("FAIL bad_head_cnts err=%0d pkt=%0d want %0d/%0d", out_err_cnt, out_pkt_cnt, exp_err, exp_pkt);
    end
    clear_capture();
    model(tbq[7]);
    grant(7);
    wait_free(40, ok);
    exp_pkt += exp_dpkt; exp_err += exp_derr;
    n_tests++; if (!ok || word_mismatches() != 0) begin n_fail++; $display("FAIL after_discard_words free=%0b mism=%0d want 1/0", ok, word_mismatches()); end
  endtask

  task automatic test_empty_grant();
    bit ok;
    clear_capture();
    tbq[3].delete();
    drive_q();
    grant(3);
    wait_free(10, ok);
    exp_err++;
    n_tests++; if (!ok || free_cyc.size() != 1 || got_words.size() != 0 || other_rden(-1) != 0) begin
      n_fail++; $display("FAIL empty_grant free=%0d words=%0d rden=%0d want 1/0/0", free_cyc.size(), got_words.size(), other_rden(-1));
    end
    n_tests++; if (out_err_cnt !== ERR_CNT_W'(exp_err)) begin n_fail++; $display("FAIL empty_grant_err got=%0d want=%0d", out_err_cnt, exp_err); end
  endtask

  task automatic test_random();
    bit ok;
    int q;
    int len;
    logic [1:0] hf;
    for (int it = 0; it < 20; it++) begin
      clear_capture();
      q   = $urandom_range(0, NUM_Q - 1);
      len = ($urandom_range(0, 6) == 0) ? $urandom_range(MAXW + 1, MAXW + 12) : $urandom_range(2, 12);
      hf  = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? FLAG_MID : FLAG_TAIL) : FLAG_HEAD;
      push_pkt(q, len, hf);
      drive_q();
      model(tbq[q]);
      grant(q);
      wait_free(400, ok);
      exp_pkt += exp_dpkt; exp_err += exp_derr;
      n_tests++; if (!ok || word_mismatches() != 0 || rden_hits[q] != exp_pops || other_rden(q) != 0 || free_cyc.size() != 1
                     || out_pkt_cnt !== PKT_CNT_W'(exp_pkt) || out_err_cnt !== ERR_CNT_W'(exp_err)) begin
        n_fail++;
        $display("FAIL rand%0d q=%0d len=%0d mism=%0d pops=%0d/%0d free=%0d pkt=%0d/%0d err=%0d/%0d", it, q, len,
                 word_mismatches(), rden_hits[q], exp_pops, free_cyc.size(), out_pkt_cnt, exp_pkt, out_err_cnt, exp_err);
      end
      tbq[q].delete();
      drive_q();
    end
  endtask

  task automatic test_reset_mid();
    clear_capture();
    push_pkt(6, 10, FLAG_HEAD);
    drive_q();
    grant(6);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    exp_pkt = 0;
    exp_err = 0;
    n_tests++; if (out_q_rden !== '0 || out_pkt_valid !== 1'b0 || out_pkt_data !== '0 || out_outport_free !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs rden=%h valid=%b data=%h free=%b want all 0", out_q_rden, out_pkt_valid, out_pkt_data, out_outport_free);
    end
    n_tests++; if (out_pkt_cnt !== '0 || out_err_cnt !== '0) begin
      n_fail++; $display("FAIL midrst_cnts pkt=%0d err=%0d want 0/0", out_pkt_cnt, out_err_cnt);
    end
    @(posedge clk);
    #1;
    n_tests++; if (out_q_rden !== '0 || out_pkt_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_edge rden=%h valid=%b want 0/0", out_q_rden, out_pkt_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
    repeat (3) step();
    n_tests++; if (other_rden(-1) != 0 || got_words.size() != 0 || tbq[6].size() != 6) begin
      n_fail++; $display("FAIL midrst_idle rden=%0d words=%0d left=%0d want 0/0/6", other_rden(-1), got_words.size(), tbq[6].size());
    end
    tbq[6].delete();
    drive_q();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_pkt = 0;
    exp_err = 0;
    cyc     = 0;
    test_reset();
    test_basic();
    test_stall();
    test_sel_err();
    test_overflow();
    test_bad_head();
    test_empty_grant();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
